// File: rtl/simple_arch_pkg.sv
// simple_arch_pkg: shared phase encodings, branch opcodes, condition codes and flag bit indices
package simple_arch_pkg;
  typedef enum logic [2:0] {
    PH_IF   = 3'd0,
    PH_ID   = 3'd1,
    PH_EX   = 3'd2,
    PH_WB   = 3'd3,
    PH_HALT = 3'd4
  } phase_t;
  localparam logic [1:0]  BR_CLASS  = 2'b10;
  localparam logic [2:0]  OP2_JMP   = 3'b100;
  localparam logic [2:0]  OP2_JCC   = 3'b111;
  localparam logic [2:0]  COND_EQ   = 3'd0;
  localparam logic [2:0]  COND_LT   = 3'd1;
  localparam logic [2:0]  COND_LE   = 3'd2;
  localparam logic [2:0]  COND_NE   = 3'd3;
  localparam logic [15:0] HALT_WORD = 16'hFFFF;
  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/branch_resolve.sv
// branch_resolve: combinational branch decision and PC-relative target from ir and flags
module branch_resolve
  import simple_arch_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic [15:0]   ir,
  input  logic [3:0]    flags,
  input  logic [AW-1:0] pc,
  output logic          taken,
  output logic [AW-1:0] target
);
  logic w_z;
  logic w_lt;
  logic w_cond_ok;
  logic w_unused_c;
  assign w_z        = flags[FLAG_Z];
  assign w_lt       = flags[FLAG_S] ^ flags[FLAG_V];
  assign w_unused_c = flags[FLAG_C];
  // Condition codes 4..7 are reserved and never taken
  always_comb
    w_cond_ok = ir[10:8] == COND_EQ ? w_z :
                ir[10:8] == COND_LT ? w_lt :
                ir[10:8] == COND_LE ? (w_z | w_lt) :
                ir[10:8] == COND_NE ? !w_z : 1'b0;
  assign taken  = ir[15:14] == BR_CLASS &&
                  (ir[13:11] == OP2_JMP || (ir[13:11] == OP2_JCC && w_cond_ok));
  assign target = pc + AW'(1) + AW'($signed(ir[7:0]));
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: IF/ID/EX/WB phase controller with PC, IR and SZCV flags; PC_SEQ_BRCNT_EN adds a taken-branch counter
module pc_sequencer
  import simple_arch_pkg::*;
#(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_rdata,
  output logic [15:0]   ir_o,
  output logic [2:0]    phase_o,
  output logic [AW-1:0] pc_o,
  input  logic          exec_done,
  input  logic          flag_we,
  input  logic [3:0]    flag_in,
  output logic [3:0]    flag_o,
`ifdef PC_SEQ_BRCNT_EN
  output logic [15:0]   brcnt_o,
`endif
  output logic          halted
);
  phase_t        r_phase;
  logic [AW-1:0] r_pc;
  logic [15:0]   r_ir;
  logic [3:0]    r_flags;
  logic          r_req;
  logic          r_halted;
  logic          w_taken;
  logic [AW-1:0] w_target;
`ifdef PC_SEQ_BRCNT_EN
  logic [15:0]   r_brcnt;
  assign brcnt_o = r_brcnt;
`endif
  // Branch decision sees the flag register before any write in the same WB cycle
  branch_resolve #(.AW(AW)) u_br (
    .ir     (r_ir),
    .flags  (r_flags),
    .pc     (r_pc),
    .taken  (w_taken),
    .target (w_target)
  );
  // Phase FSM; imem_req is registered so it rises on IF entry from WB and drops the cycle after ack
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phase  <= PH_IF;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_flags  <= '0;
      r_req    <= 1'b0;
      r_halted <= 1'b0;
`ifdef PC_SEQ_BRCNT_EN
      r_brcnt  <= '0;
`endif
    end else begin
      case (r_phase)
        PH_IF: begin
          if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_req   <= 1'b0;
            r_phase <= PH_ID;
          end else begin
            r_req   <= 1'b1;
          end
        end
        PH_ID: begin
          if (r_ir == HALT_WORD) begin
            r_phase  <= PH_HALT;
            r_halted <= 1'b1;
          end else begin
            r_phase  <= PH_EX;
          end
        end
        PH_EX: if (exec_done) r_phase <= PH_WB;
        PH_WB: begin
          if (flag_we) r_flags <= flag_in;
          r_pc    <= w_taken ? w_target : r_pc + AW'(1);
          r_req   <= 1'b1;
          r_phase <= PH_IF;
`ifdef PC_SEQ_BRCNT_EN
          if (w_taken && r_brcnt != 16'hFFFF) r_brcnt <= r_brcnt + 16'd1;
`endif
        end
        default: ;
      endcase
    end
  end
  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign pc_o      = r_pc;
  assign ir_o      = r_ir;
  assign phase_o   = r_phase;
  assign flag_o    = r_flags;
  assign halted    = r_halted;
endmodule
